// File: rtl/bitcoin_pkg.sv
// Shared definitions for the nonce sweep scheduler and its helpers.
package bitcoin_pkg;

  localparam int ADDR_W = 16;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Index width for a pool of n entries; a single entry still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nonce_dispatch_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant of the first requester at or above the
// rotating pointer; the pointer moves just past the winner when adv is set.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [N-1:0]     req,
  input  logic             adv,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] sel;
  int               slot;

  // Scan upward from the pointer with wrap-around for the first requester.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    slot        = 0;
    sel         = '0;
    for (int k = 0; k < N; k++) begin
      slot = int'(ptr) + k;
      if (slot >= N) begin
        slot = slot - N;
      end else begin
        slot = slot;
      end
      sel = IDX_W'(slot);
      if (!grant_valid && req[sel]) begin
        grant_valid = 1'b1;
        grant[sel]  = 1'b1;
        grant_idx   = sel;
      end else begin
        grant_valid = grant_valid;
      end
    end
  end

  // Pointer register: restarts at 0 per job, otherwise moves past the winner.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (adv && grant_valid) begin
      if (grant_idx == IDX_W'(N - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= grant_idx + 1'b1;
      end
    end else begin
      ptr <= ptr;
    end
  end

endmodule

// File: rtl/nonce_dispatch_ctrl.sv
// Shares a pool of SHA-256 nonce workers across a nonce sweep: launches one
// nonce per cycle to the lowest free worker, captures H0 results and writes
// them one per cycle to output_addr + nonce.
module nonce_dispatch_ctrl
  import bitcoin_pkg::*;
#(
  parameter int NUM_NONCES = 16,
  parameter int NUM_CORES  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           output_addr,
  output logic                        done,
  output logic [NUM_CORES-1:0]        core_start,
  output logic [WORD_W-1:0]           core_nonce,
  input  logic [NUM_CORES-1:0]        core_done,
  input  logic [NUM_CORES*WORD_W-1:0] core_h0,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [WORD_W-1:0]           mem_write_data,
  output logic                        proto_err
);

  localparam int IDX_W = idx_width(NUM_CORES);
  localparam int CNT_W = 17;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(NUM_NONCES);

  state_t               state, state_next;
  logic                 arm, in_run;
  logic [ADDR_W-1:0]    base;
  logic [CNT_W-1:0]     next_nonce, written;
  logic [NUM_CORES-1:0] busy, pending, free, collect;
  logic [NUM_CORES-1:0] busy_next, pending_next, disp_onehot, wr_grant;
  logic [ADDR_W-1:0]    tag    [NUM_CORES];
  logic [WORD_W-1:0]    result [NUM_CORES];
  logic                 disp_found, do_dispatch, do_write, wr_valid, spurious;
  logic [IDX_W-1:0]     disp_idx, wr_idx;

  assign in_run = (state == ST_RUN);

  rr_arbiter #(.N(NUM_CORES), .IDX_W(IDX_W)) u_wr_arb (
    .clk         (clk),
    .reset       (reset),
    .clear       (arm),
    .req         (pending & {NUM_CORES{in_run}}),
    .adv         (do_write),
    .grant       (wr_grant),
    .grant_idx   (wr_idx),
    .grant_valid (wr_valid)
  );

  // Next-state logic; arm marks an accepted start (from IDLE or DONE).
  always_comb begin
    state_next = state;
    arm        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_RUN;
          arm        = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (written == LIMIT) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_next = ST_RUN;
          arm        = 1'b1;
        end else begin
          state_next = ST_DONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Dispatch pick, result collection and write bookkeeping for this cycle.
  always_comb begin
    free        = ~busy & ~pending;
    disp_found  = 1'b0;
    disp_idx    = '0;
    disp_onehot = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!disp_found && free[i]) begin
        disp_found = 1'b1;
        disp_idx   = IDX_W'(i);
      end else begin
        disp_found = disp_found;
      end
    end
    do_dispatch = in_run && disp_found && (next_nonce < LIMIT);
    if (do_dispatch) begin
      disp_onehot[disp_idx] = 1'b1;
    end else begin
      disp_onehot = '0;
    end
    collect      = core_done & busy & {NUM_CORES{in_run}};
    spurious     = in_run && (|(core_done & ~busy));
    do_write     = in_run && wr_valid;
    busy_next    = (busy & ~collect) | disp_onehot;
    pending_next = (pending | collect) & ~(do_write ? wr_grant : {NUM_CORES{1'b0}});
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Worker bookkeeping, result storage and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      base           <= '0;
      next_nonce     <= '0;
      written        <= '0;
      busy           <= '0;
      pending        <= '0;
      done           <= 1'b0;
      core_start     <= '0;
      core_nonce     <= '0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      proto_err      <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
        tag[i]    <= '0;
        result[i] <= '0;
      end
    end else begin
      done       <= (state_next == ST_DONE);
      core_start <= disp_onehot;
      mem_we     <= do_write;
      if (spurious) begin
        proto_err <= 1'b1;
      end
      if (arm) begin
        base       <= output_addr;
        next_nonce <= '0;
        written    <= '0;
        busy       <= '0;
        pending    <= '0;
        for (int i = 0; i < NUM_CORES; i++) begin
          tag[i] <= '0;
        end
      end else begin
        busy    <= busy_next;
        pending <= pending_next;
        if (do_dispatch) begin
          core_nonce    <= {{(WORD_W - CNT_W){1'b0}}, next_nonce};
          tag[disp_idx] <= next_nonce[ADDR_W-1:0];
          next_nonce    <= next_nonce + 1'b1;
        end
        for (int i = 0; i < NUM_CORES; i++) begin
          if (collect[i]) begin
            result[i] <= core_h0[i*WORD_W +: WORD_W];
          end
        end
        if (do_write) begin
          mem_addr       <= base + tag[wr_idx];
          mem_write_data <= result[wr_idx];
          written        <= written + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nonce_dispatch_ctrl.sv
// Bench for nonce_dispatch_ctrl: instance A sweeps 16 nonces, instance B sweeps
// 3 nonces over 4 workers. Bench workers push expected writes to a scoreboard.
module tb_nonce_dispatch_ctrl;

  localparam int NC = 4;
  localparam int NA = 16;
  localparam int NB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        a_start, a_done, a_mem_we, a_perr;
  logic [15:0] a_addr, a_mem_addr;
  logic [3:0]  a_core_start, a_core_done;
  logic [31:0] a_core_nonce, a_mem_data;
  logic [127:0] a_core_h0;

  logic        b_start, b_done, b_mem_we, b_perr;
  logic [15:0] b_addr, b_mem_addr;
  logic [3:0]  b_core_start, b_core_done;
  logic [31:0] b_core_nonce, b_mem_data;
  logic [127:0] b_core_h0;

  nonce_dispatch_ctrl #(.NUM_NONCES(NA), .NUM_CORES(NC)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .output_addr(a_addr), .done(a_done),
    .core_start(a_core_start), .core_nonce(a_core_nonce), .core_done(a_core_done),
    .core_h0(a_core_h0), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_write_data(a_mem_data), .proto_err(a_perr)
  );

  nonce_dispatch_ctrl #(.NUM_NONCES(NB), .NUM_CORES(NC)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .output_addr(b_addr), .done(b_done),
    .core_start(b_core_start), .core_nonce(b_core_nonce), .core_done(b_core_done),
    .core_h0(b_core_h0), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_write_data(b_mem_data), .proto_err(b_perr)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int tcount   = 0;

  // Scoreboard entries: {push tick[15:0], address[15:0], data[31:0]}.
  logic [63:0] qa[$];
  logic [63:0] qb[$];

  int          lat    [2][NC];
  int          cnt    [2][NC];
  bit          active [2][NC];
  logic [15:0] mtag   [2][NC];
  int          exp_nonce [2];
  int          writes    [2];
  logic [15:0] base      [2];
  logic [3:0]  started   [2];
  bit          exact     [2];
  logic        prev_we   [2];
  logic        prev_done [2];
  int          run_len   [2];
  int          max_run   [2];

  function automatic logic [31:0] h0_of(input logic [15:0] n);
    return {n ^ 16'hC0DE, n * 16'd59 + 16'h1234};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One instance per cycle: worker model, launch checks, write scoreboard.
  task automatic inst_step(input int k, input logic [3:0] cs, input logic [31:0] cn,
                           input logic we, input logic [15:0] ma, input logic [31:0] md,
                           input logic dn, output logic [3:0] cd, output logic [127:0] h0);
    logic [63:0] e;
    logic [15:0] a;
    int sz;
    cd = '0;
    h0 = '0;
    for (int i = 0; i < NC; i++) begin
      if (active[k][i]) begin
        cnt[k][i]--;
        if (cnt[k][i] == 0) begin
          active[k][i] = 1'b0;
          cd[i] = 1'b1;
          h0[i*32 +: 32] = h0_of(mtag[k][i]);
          a = base[k] + mtag[k][i];
          e = {16'(tcount), a, h0_of(mtag[k][i])};
          if (k == 0) qa.push_back(e); else qb.push_back(e);
        end
      end
    end
    if (cs != 4'd0) begin
      check("core_start_onehot", 64'($onehot(cs)), 64'd1);
    end
    for (int i = 0; i < NC; i++) begin
      if (cs[i]) begin
        check("core_nonce", cn, 64'(exp_nonce[k]));
        check("worker_not_busy", 64'(active[k][i]), 64'd0);
        mtag[k][i] = cn[15:0];
        exp_nonce[k]++;
        active[k][i] = 1'b1;
        cnt[k][i] = lat[k][i];
        started[k][i] = 1'b1;
      end
    end
    if (we) begin
      sz = (k == 0) ? qa.size() : qb.size();
      check("write_expected", 64'(sz > 0), 64'd1);
      if (sz > 0) begin
        if (k == 0) e = qa.pop_front(); else e = qb.pop_front();
        check("mem_addr", 64'(ma), 64'(e[47:32]));
        check("mem_data", 64'(md), 64'(e[31:0]));
        if (exact[k]) check("write_latency", 64'(tcount - int'(e[63:48])), 64'd2);
        writes[k]++;
      end
      run_len[k]++;
      if (run_len[k] > max_run[k]) max_run[k] = run_len[k];
    end else begin
      run_len[k] = 0;
    end
    if (dn && !prev_done[k]) begin
      check("done_after_last_write", 64'(prev_we[k]), 64'd1);
      check("writes_at_done", 64'(writes[k]), 64'((k == 0) ? NA : NB));
    end
    prev_we[k]   = we;
    prev_done[k] = dn;
  endtask

  task automatic tick();
    logic [3:0]   cd;
    logic [127:0] h;
    @(posedge clk);
    #1;
    tcount++;
    inst_step(0, a_core_start, a_core_nonce, a_mem_we, a_mem_addr, a_mem_data, a_done, cd, h);
    a_core_done = cd;
    a_core_h0   = h;
    inst_step(1, b_core_start, b_core_nonce, b_mem_we, b_mem_addr, b_mem_data, b_done, cd, h);
    b_core_done = cd;
    b_core_h0   = h;
  endtask

  task automatic start_job(input int k, input logic [15:0] addr);
    base[k] = addr;
    exp_nonce[k] = 0;
    writes[k] = 0;
    started[k] = '0;
    if (k == 0) begin a_start = 1'b1; a_addr = addr; end
    else begin b_start = 1'b1; b_addr = addr; end
    tick();
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget, input string tag);
    int i = 0;
    while (!((k == 0) ? a_done : b_done) && i < budget) begin
      tick();
      i++;
    end
    check(tag, 64'((k == 0) ? a_done : b_done), 64'd1);
    check("scoreboard_empty", 64'((k == 0) ? qa.size() : qb.size()), 64'd0);
  endtask

  task automatic check_zero_outputs();
    check("rst_done", 64'(a_done), 64'd0);
    check("rst_core_start", 64'(a_core_start), 64'd0);
    check("rst_core_nonce", 64'(a_core_nonce), 64'd0);
    check("rst_mem_we", 64'(a_mem_we), 64'd0);
    check("rst_mem_addr", 64'(a_mem_addr), 64'd0);
    check("rst_mem_data", 64'(a_mem_data), 64'd0);
    check("rst_proto_err", 64'(a_perr), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    a_start = 1'b0; a_addr = '0; a_core_done = '0; a_core_h0 = '0;
    b_start = 1'b0; b_addr = '0; b_core_done = '0; b_core_h0 = '0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NC; i++) begin
        lat[k][i] = (k == 0) ? 70 : 10;
        active[k][i] = 1'b0;
        cnt[k][i] = 0;
        mtag[k][i] = '0;
      end
      exp_nonce[k] = 0; writes[k] = 0; base[k] = '0; started[k] = '0;
      exact[k] = 1'b1; prev_we[k] = 1'b0; prev_done[k] = 1'b0;
      run_len[k] = 0; max_run[k] = 0;
    end

    // Reset values.
    tick();
    check_zero_outputs();
    reset = 1'b0;
    tick();

    // Job 1: A at 0x0100 with 70-cycle workers; B sweeps 3 nonces over 4 workers.
    start_job(1, 16'h0200);
    start_job(0, 16'h0100);
    check("first_start_cycle1", 64'(a_core_start), 64'd0);
    tick();
    check("first_start_cycle2", 64'(a_core_start), 64'h1);
    wait_done(1, 200, "b_done");
    check("b_writes", 64'(writes[1]), 64'(NB));
    check("b_worker3_never_started", 64'(started[1][3]), 64'd0);
    check("b_proto_err", 64'(b_perr), 64'd0);
    wait_done(0, 2000, "a_done");
    check("a_writes", 64'(writes[0]), 64'(NA));
    check("a_proto_err_clean", 64'(a_perr), 64'd0);
    check("b_done_held", 64'(b_done), 64'd1);

    // Job 2: re-arm from DONE, simultaneous completions, spurious done, start in RUN.
    for (int i = 0; i < NC; i++) lat[0][i] = 73 - i;
    exact[0] = 1'b0;
    max_run[0] = 0;
    start_job(0, 16'h0100);
    check("done_drops_on_rearm", 64'(a_done), 64'd0);
    a_core_done[2] = 1'b1;
    a_core_h0[95:64] = 32'hDEADBEEF;
    tick();
    check("proto_err_set", 64'(a_perr), 64'd1);
    for (int i = 0; i < 5; i++) tick();
    a_start = 1'b1;
    a_addr = 16'h0BAD;
    tick();
    a_start = 1'b0;
    wait_done(0, 2000, "a_done_job2");
    check("a_writes_job2", 64'(writes[0]), 64'(NA));
    check("burst_of_four_writes", 64'(max_run[0] >= 4), 64'd1);
    check("proto_err_sticky", 64'(a_perr), 64'd1);

    // Job 3: reset mid-RUN, then a wrapping sweep from 0xFFFE.
    for (int i = 0; i < NC; i++) lat[0][i] = 70;
    exact[0] = 1'b1;
    start_job(0, 16'hFFFE);
    for (int i = 0; i < 20; i++) tick();
    reset = 1'b1;
    for (int i = 0; i < NC; i++) active[0][i] = 1'b0;
    qa.delete();
    a_core_done = '0;
    tick();
    reset = 1'b0;
    check_zero_outputs();
    a_core_done[1] = 1'b1;
    tick();
    check("proto_err_idle_ignored", 64'(a_perr), 64'd0);
    tick();
    check("idle_no_launch", 64'(a_core_start), 64'd0);
    for (int i = 0; i < NC; i++) lat[0][i] = 5;
    start_job(0, 16'hFFFE);
    wait_done(0, 1000, "a_done_wrap");
    check("a_writes_wrap", 64'(writes[0]), 64'(NA));
    check("a_proto_err_wrap", 64'(a_perr), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
